// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel/line counters, horizontal and vertical
// phase FSMs, and registered sync/active flags aligned with the counters.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each phase; every phase is assumed at least one count long.
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SYN_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SYN_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    H_ACT = 2'd0,
    H_FP  = 2'd1,
    H_SYN = 2'd2,
    H_BP  = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_ACT = 2'd0,
    V_FP  = 2'd1,
    V_SYN = 2'd2,
    V_BP  = 2'd3
  } v_state_e;

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       h_wrap;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    h_wrap   = 1'b0;
    if (enable) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 10'd0;
        h_wrap   = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d = 10'd0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q;
    end
  end

  always_comb begin
    h_state_d = h_state_q;
    if (enable) begin
      case (h_state_q)
        H_ACT: if (hcount_q == H_ACT_LAST) h_state_d = H_FP;  else h_state_d = H_ACT;
        H_FP:  if (hcount_q == H_FP_LAST)  h_state_d = H_SYN; else h_state_d = H_FP;
        H_SYN: if (hcount_q == H_SYN_LAST) h_state_d = H_BP;  else h_state_d = H_SYN;
        H_BP:  if (hcount_q == H_LAST)     h_state_d = H_ACT; else h_state_d = H_BP;
        default: h_state_d = H_ACT;
      endcase
    end else begin
      h_state_d = h_state_q;
    end
  end

  // Vertical phase only moves on the enabled cycle where the line wraps.
  always_comb begin
    v_state_d = v_state_q;
    if (h_wrap) begin
      case (v_state_q)
        V_ACT: if (vcount_q == V_ACT_LAST) v_state_d = V_FP;  else v_state_d = V_ACT;
        V_FP:  if (vcount_q == V_FP_LAST)  v_state_d = V_SYN; else v_state_d = V_FP;
        V_SYN: if (vcount_q == V_SYN_LAST) v_state_d = V_BP;  else v_state_d = V_SYN;
        V_BP:  if (vcount_q == V_LAST)     v_state_d = V_ACT; else v_state_d = V_BP;
        default: v_state_d = V_ACT;
      endcase
    end else begin
      v_state_d = v_state_q;
    end
  end

  // Flags derive from next-state phases so they land on the same edge as the counters.
  always_comb begin
    hsync_d  = ~SYNC_ON;
    vsync_d  = ~SYNC_ON;
    active_d = 1'b0;
    if (h_state_d == H_SYN) begin
      hsync_d = SYNC_ON;
    end else begin
      hsync_d = ~SYNC_ON;
    end
    if (v_state_d == V_SYN) begin
      vsync_d = SYNC_ON;
    end else begin
      vsync_d = ~SYNC_ON;
    end
    active_d = (h_state_d == H_ACT) && (v_state_d == V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q  <= 10'd0;
      vcount_q  <= 10'd0;
      h_state_q <= H_ACT;
      v_state_q <= V_ACT;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      active_q  <= 1'b1;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = enable & ~rst & (hcount_q == 10'd0);
  assign frame_start = enable & ~rst & (hcount_q == 10'd0) & (vcount_q == 10'd0);

endmodule
